// File: rtl/pc_unit.sv
// pc_unit: program-counter unit for the single-cycle core.
// Owns the PC register and selects the next PC from the sequential, branch,
// jump, trap-entry and trap-return paths. It also tracks the saved exception
// PC and trap cause, and enters a halted state on a double fault.
// Optional feature macro: PC_COMPRESSED_EN. When it is defined, 16-bit
// instructions use a 2-byte increment and only target bit 0 must be clear.
module pc_unit #(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0]  TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_stall,
  input  logic             i_branch_taken,
  input  logic [XLEN-1:0]  i_branch_target,
  input  logic             i_jump,
  input  logic [XLEN-1:0]  i_jump_target,
  input  logic             i_trap_req,
  input  logic             i_mret,
`ifdef PC_COMPRESSED_EN
  input  logic             i_compressed,
`endif
  output logic [XLEN-1:0]  o_pc,
  output logic [XLEN-1:0]  o_pc_seq,
  output logic             o_valid,
  output logic [XLEN-1:0]  o_epc,
  output logic [1:0]       o_cause,
  output logic             o_in_trap,
  output logic             o_trap_ack,
  output logic             o_halted
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    HANDLER = 2'd2,
    HALT    = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_EXT  = 2'd1;
  localparam logic [1:0] CAUSE_MIS  = 2'd2;

  localparam logic [XLEN-1:0] INC_WORD = XLEN'(4);
`ifdef PC_COMPRESSED_EN
  localparam logic [XLEN-1:0] INC_HALF = XLEN'(2);
`endif

  // A redirect target is unusable if it breaks the fetch alignment rule.
  function automatic logic target_misaligned(input logic [1:0] low_bits);
`ifdef PC_COMPRESSED_EN
    return low_bits[0];
`else
    return |low_bits;
`endif
  endfunction

  state_t           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  epc_q, epc_d;
  logic [1:0]       cause_q, cause_d;
  logic             ack_q, ack_d;

  logic [XLEN-1:0]  pc_seq;
  logic [XLEN-1:0]  sel_target;
  logic             redirect;
  logic             mis_trap;

  // Sequential address: wraps modulo 2^XLEN naturally.
  always_comb begin
`ifdef PC_COMPRESSED_EN
    pc_seq = pc_q + (i_compressed ? INC_HALF : INC_WORD);
`else
    pc_seq = pc_q + INC_WORD;
`endif
  end

  // Jump takes precedence over branch when choosing which target to validate.
  always_comb begin
    sel_target = i_jump ? i_jump_target : i_branch_target;
    redirect   = i_jump | i_branch_taken;
    mis_trap   = redirect & target_misaligned(sel_target[1:0]);
  end

  // Next-state and next-PC selection; a stall leaves every register as is
  // and drops the acknowledge.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    ack_d   = 1'b0;
    if (!i_stall) begin
      unique case (state_q)
        BOOT: begin
          // PC already holds the reset vector; just start fetching.
          state_d = RUN;
        end
        RUN, HANDLER: begin
          if (i_trap_req || mis_trap) begin
            // External request outranks a misaligned target in the same cycle.
            ack_d = i_trap_req;
            if (state_q == RUN) begin
              epc_d   = pc_q;
              cause_d = i_trap_req ? CAUSE_EXT : CAUSE_MIS;
              pc_d    = TRAP_VECTOR;
              state_d = HANDLER;
            end else begin
              // Trap while already handling one: freeze PC/EPC/cause.
              state_d = HALT;
            end
          end else if (i_mret && (state_q == HANDLER)) begin
            pc_d    = epc_q;
            state_d = RUN;
          end else if (i_jump) begin
            pc_d = i_jump_target;
          end else if (i_branch_taken) begin
            pc_d = i_branch_target;
          end else begin
            pc_d = pc_seq;
          end
        end
        HALT: begin
          // Only reset leaves this state.
          state_d = HALT;
        end
        default: begin
          state_d = BOOT;
        end
      endcase
    end
  end

  // State, PC and trap bookkeeping registers with asynchronous reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      cause_q <= CAUSE_NONE;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      ack_q   <= ack_d;
    end
  end

  // Status flags decode directly from the state register.
  always_comb begin
    o_pc       = pc_q;
    o_pc_seq   = pc_seq;
    o_epc      = epc_q;
    o_cause    = cause_q;
    o_trap_ack = ack_q;
    o_valid    = (state_q == RUN) || (state_q == HANDLER);
    o_in_trap  = (state_q == HANDLER);
    o_halted   = (state_q == HALT);
  end

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit: table of {inputs, expected outputs} records driven
// one clock at a time through a scoreboard queue, followed by hand-written
// sequences for asynchronous reset, stall in BOOT, double fault by a
// misaligned target, and PC wrap-around.
module tb_pc_unit;

  localparam logic [31:0] RV = 32'h0000_0064;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic        stall, br, jmp, trap, mret, compressed;
  logic [31:0] bt, jt;
  logic [31:0] pc, pc_seq, epc;
  logic        valid, in_trap, ack, halted;
  logic [1:0]  cause;

  int total;
  int bad;

  pc_unit #(
    .XLEN         (32),
    .RESET_VECTOR (RV),
    .TRAP_VECTOR  (TV)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_stall         (stall),
    .i_branch_taken  (br),
    .i_branch_target (bt),
    .i_jump          (jmp),
    .i_jump_target   (jt),
    .i_trap_req      (trap),
    .i_mret          (mret),
`ifdef PC_COMPRESSED_EN
    .i_compressed    (compressed),
`endif
    .o_pc            (pc),
    .o_pc_seq        (pc_seq),
    .o_valid         (valid),
    .o_epc           (epc),
    .o_cause         (cause),
    .o_in_trap       (in_trap),
    .o_trap_ack      (ack),
    .o_halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic        trap;
    logic        mret;
    logic        cmp;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic        in_trap;
    logic        ack;
    logic        halted;
  } vec_t;

  vec_t vecs[$];
  vec_t sbq[$];

  function automatic vec_t mk(input logic s, input logic b, input logic [31:0] btv,
                              input logic j, input logic [31:0] jtv, input logic t,
                              input logic m, input logic [31:0] epc_pc, input logic v,
                              input logic [31:0] e, input logic [1:0] c, input logic it,
                              input logic a, input logic h);
    vec_t r;
    r.stall = s;   r.br = b;    r.bt = btv;  r.jmp = j;   r.jt = jtv;
    r.trap = t;    r.mret = m;  r.cmp = 1'b0;
    r.pc = epc_pc; r.valid = v; r.epc = e;   r.cause = c;
    r.in_trap = it; r.ack = a;  r.halted = h;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_outputs(input string tag, input vec_t e);
    chk({tag, ".pc"},      pc,               e.pc);
    chk({tag, ".pc_seq"},  pc_seq,           e.pc + (compressed ? 32'd2 : 32'd4));
    chk({tag, ".valid"},   {31'd0, valid},   {31'd0, e.valid});
    chk({tag, ".epc"},     epc,              e.epc);
    chk({tag, ".cause"},   {30'd0, cause},   {30'd0, e.cause});
    chk({tag, ".in_trap"}, {31'd0, in_trap}, {31'd0, e.in_trap});
    chk({tag, ".ack"},     {31'd0, ack},     {31'd0, e.ack});
    chk({tag, ".halted"},  {31'd0, halted},  {31'd0, e.halted});
  endtask

  // Drive one record, clock once, then compare 1 ns after the edge.
  task automatic step(input string tag, input vec_t v);
    vec_t e;
    stall = v.stall; br = v.br; bt = v.bt; jmp = v.jmp; jt = v.jt;
    trap = v.trap;   mret = v.mret; compressed = v.cmp;
    sbq.push_back(v);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sbq.pop_front();
      compare_outputs(tag, e);
    end
  endtask

  // Asynchronous reset pulse between clock edges, checked before any edge.
  task automatic async_reset(input string tag);
    vec_t r;
    r = mk(0,0,0, 0,0, 0,0, RV,0, 32'd0,2'd0, 0,0,0);
    #2;
    rst_n = 1'b0;
    #1;
    compare_outputs(tag, r);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  vec_t hv;

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    stall = 0; br = 0; jmp = 0; trap = 0; mret = 0; compressed = 0;
    bt = '0; jt = '0;

    //        st br bt            j  jt            tr mr pc            v  epc   ca it ak h
    vecs.push_back(mk(0,0,0,            0,0,            0,0, 32'h064, 1, 32'h0, 0, 0,0,0)); // BOOT->RUN
    vecs.push_back(mk(0,0,0,            0,0,            0,0, 32'h068, 1, 32'h0, 0, 0,0,0));
    vecs.push_back(mk(0,0,0,            0,0,            0,0, 32'h06C, 1, 32'h0, 0, 0,0,0));
    vecs.push_back(mk(0,0,0,            0,0,            0,0, 32'h070, 1, 32'h0, 0, 0,0,0));
    vecs.push_back(mk(0,0,0,            1,32'h200,      0,0, 32'h200, 1, 32'h0, 0, 0,0,0)); // jump
    vecs.push_back(mk(0,1,32'h300,      1,32'h400,      0,0, 32'h400, 1, 32'h0, 0, 0,0,0)); // jump beats branch
    vecs.push_back(mk(0,1,32'h500,      0,0,            0,0, 32'h500, 1, 32'h0, 0, 0,0,0)); // branch
    vecs.push_back(mk(1,0,0,            1,32'h700,      0,0, 32'h500, 1, 32'h0, 0, 0,0,0)); // stalled jump
    vecs.push_back(mk(0,0,0,            1,32'h080,      0,0, 32'h080, 1, 32'h0, 0, 0,0,0));
    vecs.push_back(mk(0,0,0,            1,32'h201,      0,0, 32'h100, 1, 32'h80,2, 1,0,0)); // misaligned trap
    vecs.push_back(mk(0,0,0,            0,0,            0,0, 32'h104, 1, 32'h80,2, 1,0,0));
    vecs.push_back(mk(0,0,0,            1,32'h600,      0,1, 32'h080, 1, 32'h80,2, 0,0,0)); // mret beats jump
    vecs.push_back(mk(0,0,0,            0,0,            0,1, 32'h084, 1, 32'h80,2, 0,0,0)); // mret in RUN ignored
    vecs.push_back(mk(0,1,32'h090,      0,0,            0,1, 32'h090, 1, 32'h80,2, 0,0,0));
    vecs.push_back(mk(1,0,0,            0,0,            1,0, 32'h090, 1, 32'h80,2, 0,0,0)); // stalled trap x3
    vecs.push_back(mk(1,0,0,            0,0,            1,0, 32'h090, 1, 32'h80,2, 0,0,0));
    vecs.push_back(mk(1,0,0,            0,0,            1,0, 32'h090, 1, 32'h80,2, 0,0,0));
    vecs.push_back(mk(0,0,0,            0,0,            1,0, 32'h100, 1, 32'h90,1, 1,1,0)); // external trap
    vecs.push_back(mk(0,0,0,            0,0,            0,0, 32'h104, 1, 32'h90,1, 1,0,0));
    vecs.push_back(mk(0,0,0,            0,0,            0,1, 32'h090, 1, 32'h90,1, 0,0,0));
    vecs.push_back(mk(0,0,0,            1,32'h203,      1,0, 32'h100, 1, 32'h90,1, 1,1,0)); // ext beats misaligned
    vecs.push_back(mk(0,0,0,            0,0,            0,0, 32'h104, 1, 32'h90,1, 1,0,0));
    vecs.push_back(mk(0,0,0,            0,0,            1,0, 32'h104, 0, 32'h90,1, 0,1,1)); // double fault
    vecs.push_back(mk(0,0,0,            1,32'h400,      0,0, 32'h104, 0, 32'h90,1, 0,0,1));
    vecs.push_back(mk(0,0,0,            0,0,            0,1, 32'h104, 0, 32'h90,1, 0,0,1));
    vecs.push_back(mk(0,1,32'h300,      1,32'h500,      0,1, 32'h104, 0, 32'h90,1, 0,0,1));
    vecs.push_back(mk(0,0,0,            0,0,            1,0, 32'h104, 0, 32'h90,1, 0,0,1));
    vecs.push_back(mk(0,0,0,            1,32'h800,      0,1, 32'h104, 0, 32'h90,1, 0,0,1));

    // Reset held across clock edges.
    repeat (3) @(posedge clk);
    #1;
    hv = mk(0,0,0, 0,0, 0,0, RV,0, 32'd0,2'd0, 0,0,0);
    compare_outputs("reset_hold", hv);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset from HALT clears everything immediately.
    async_reset("rst_from_halt");

    // Stall in BOOT keeps o_valid low and PC at the reset vector.
    step("boot_stall", mk(1,0,0, 0,0, 0,0, RV,0, 32'h0,0, 0,0,0));
    step("boot_exit",  mk(0,0,0, 0,0, 0,0, RV,1, 32'h0,0, 0,0,0));
    step("to_80",      mk(0,0,0, 1,32'h80, 0,0, 32'h80,1, 32'h0,0, 0,0,0));
`ifdef PC_COMPRESSED_EN
    step("jmp_202_ok", mk(0,0,0, 1,32'h202, 0,0, 32'h202,1, 32'h0,0, 0,0,0));
    step("br_odd_trap",mk(0,1,32'h301, 0,0, 0,0, 32'h100,1, 32'h202,2, 1,0,0));
    step("br_odd_halt",mk(0,1,32'h303, 0,0, 0,0, 32'h100,0, 32'h202,2, 0,0,1));
`else
    step("jmp_202_trap", mk(0,0,0, 1,32'h202, 0,0, 32'h100,1, 32'h80,2, 1,0,0));
    step("mis_in_hndlr", mk(0,1,32'h302, 0,0, 0,0, 32'h100,0, 32'h80,2, 0,0,1));
`endif
    step("halt_hold",  mk(0,0,0, 1,32'h40, 1,1, 32'h100,0,
`ifdef PC_COMPRESSED_EN
                          32'h202,
`else
                          32'h80,
`endif
                          2, 0,0,1));

    // Reset from HANDLER-derived HALT again, then PC wrap-around.
    async_reset("rst_again");
    step("boot_exit2", mk(0,0,0, 0,0, 0,0, RV,1, 32'h0,0, 0,0,0));
    step("to_top",     mk(0,0,0, 1,32'hFFFF_FFFC, 0,0, 32'hFFFF_FFFC,1, 32'h0,0, 0,0,0));
    step("wrap4",      mk(0,0,0, 0,0, 0,0, 32'h0,1, 32'h0,0, 0,0,0));
`ifdef PC_COMPRESSED_EN
    step("to_fffe",    mk(0,0,0, 1,32'hFFFF_FFFE, 0,0, 32'hFFFF_FFFE,1, 32'h0,0, 0,0,0));
    hv = mk(0,0,0, 0,0, 0,0, 32'h0,1, 32'h0,0, 0,0,0);
    hv.cmp = 1'b1;
    step("wrap2",      hv);
`endif

    // Async reset while running from a non-reset PC.
    async_reset("rst_in_run");

    if (sbq.size() != 0) begin
      total++; bad++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sbq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the single-cycle core. It replaces the plain next-PC register with an internal next-PC selector covering sequential, branch, jump, trap-entry and trap-return paths. It adds stall, misaligned-target detection, saved exception PC, and a halt-on-double-fault state. It sits between the branch/jump resolution logic and the instruction memory address port.

## Interface
- XLEN, 32, PC/address width
- RESET_VECTOR, 32'h0000_0000, PC value held during and after reset
- TRAP_VECTOR, 32'h0000_0100, handler entry address
- i_clk  in  1  clock, rising-edge active
- i_rst_n  in  1  reset, asynchronous, active-low
- i_stall  in  1  freeze all state this cycle
- i_branch_taken  in  1  load i_branch_target
- i_branch_target  in  XLEN  branch destination
- i_jump  in  1  load i_jump_target
- i_jump_target  in  XLEN  jump destination
- i_trap_req  in  1  external trap request, level; requester holds it until o_trap_ack
- i_mret  in  1  return from handler
- i_compressed  in  1  current instruction is 16-bit (present only with PC_COMPRESSED_EN)
- o_pc  out  XLEN  current PC
- o_pc_seq  out  XLEN  o_pc + increment, combinational
- o_valid  out  1  o_pc is fetchable
- o_epc  out  XLEN  saved PC of last trap
- o_cause  out  2  last trap cause: 0 none, 1 external, 2 misaligned target
- o_in_trap  out  1  in handler
- o_trap_ack  out  1  one-cycle pulse, trap accepted
- o_halted  out  1  double fault, frozen

## Operation
- States: BOOT, RUN, HANDLER, HALT.
- BOOT: entered on reset. First edge after reset release -> RUN; PC stays RESET_VECTOR; o_valid rises.
- Per non-stalled edge in RUN/HANDLER, priority (highest first):
  1. i_trap_req: external trap.
  2. Selected target misaligned (jump if i_jump, else branch if i_branch_taken): misaligned trap; target not loaded.
  3. i_mret in HANDLER: PC <= o_epc, -> RUN, o_in_trap=0.
  4. i_jump: PC <= i_jump_target.
  5. i_branch_taken: PC <= i_branch_target.
  6. Otherwise PC <= o_pc_seq.
- i_mret in RUN is ignored; falls through to 4-6.
- Trap from RUN:
  - o_epc <= current o_pc; o_cause <= 1 or 2.
  - PC <= TRAP_VECTOR; -> HANDLER; o_in_trap=1.
  - o_trap_ack pulses for external traps only.
- Trap (either cause) from HANDLER:
  - -> HALT; o_halted=1; o_valid=0.
  - PC, o_epc and o_cause are frozen; o_trap_ack pulses if external.
- HALT: all inputs are ignored; only reset exits.
- i_stall=1: no register changes and o_trap_ack=0, in all states.
- Arithmetic: o_pc_seq = o_pc + 4, modulo 2^XLEN (all-ones-minus-3 wraps to 0). Target and vector values are used unmodified.
- Misaligned check: target[1:0] != 0.

## Timing
- All state updates on the rising i_clk edge; inputs are sampled at that edge.
- A redirect appears on o_pc one cycle after it is asserted.
- o_pc_seq is combinational from o_pc.
- Reset values, immediate on i_rst_n low regardless of clock:
  - o_pc=RESET_VECTOR, o_valid=0, o_epc=0, o_cause=0.
  - o_in_trap=0, o_trap_ack=0, o_halted=0.
- Reset mid-operation (including from HANDLER or HALT) aborts everything and returns to BOOT.
- Simultaneous events:
  - i_trap_req with a misaligned jump: external wins, cause=1.
  - i_jump with i_branch_taken: jump wins.
  - i_mret with i_jump in HANDLER: mret wins.

## Configuration
- PC_COMPRESSED_EN defined:
  - i_compressed port exists.
  - Increment is 2 when i_compressed=1, otherwise 4.
  - Misaligned check is target[0] != 0 only.
- PC_COMPRESSED_EN undefined:
  - No i_compressed port.
  - Increment is always 4.
  - Misaligned check is target[1:0] != 0.

## Test plan
- RESET_VECTOR=32'h64; hold reset, release, run 4 cycles -> o_pc 0x64 (o_valid=0), 0x64 (o_valid=1), 0x68, 0x6C, 0x70.
- Jump to 0x200 at PC 0x70, then branch+jump together (branch 0x300, jump 0x400) -> o_pc 0x200, then 0x400.
- Jump to 0x202 at PC 0x80 (macro off) -> o_pc=0x100, o_epc=0x80, o_cause=2, o_in_trap=1, o_trap_ack=0. Then mret -> o_pc=0x80, o_in_trap=0.
- i_trap_req at PC 0x90 while i_stall=1 for 3 cycles, then stall drops -> o_pc holds 0x90 during stall, then 0x100 with a one-cycle o_trap_ack, o_epc=0x90, o_cause=1.
- In HANDLER, assert i_trap_req -> o_halted=1, o_valid=0, o_pc frozen at its handler value; next 5 cycles of jumps and mret have no effect; pulse i_rst_n low -> o_pc=RESET_VECTOR, all flags cleared.
- With PC_COMPRESSED_EN and XLEN=32: PC 0xFFFF_FFFE with i_compressed=1 -> o_pc 0x0. Jump to 0x202 -> taken, no trap.
